// File: rtl/serial_lteq_cmp_pkg.sv
// Shared types and sizing helpers for the digit-serial a<=b comparator (package cmp_pkg).
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndigits(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit sweep still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_lteq_cmp_digit_cmp.sv
// Combinational DIGIT-bit magnitude compare feeding the serial le chain.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_lteq_cmp.sv
// Digit-serial a<=b comparator: LSB-first sweep, DIGIT bits per cycle, valid/ready on both sides.
// Optional macro SERIAL_CMP_SIGNED_EN switches to a two's-complement compare.
module serial_lteq_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lteq,
  output logic             busy
);

  localparam int NDIGITS = ndigits(WIDTH, DIGIT);
  localparam int CW      = cnt_width(NDIGITS);
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  state_e           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             le;
  logic             lteq_q;

  logic [DIGIT-1:0] ad, bd;
  logic             d_lt, d_eq, le_next, last_digit, accept;

  assign last_digit = (cnt == LAST);
  assign accept     = (state == IDLE) && in_valid;

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping both sign bits on the top digit maps two's complement onto unsigned order.
  logic [DIGIT-1:0] msb_flip;
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    msb_flip            = '0;
    msb_flip[DIGIT-1]   = last_digit;
  end
  assign ad = a_sh[DIGIT-1:0] ^ msb_flip;
  assign bd = b_sh[DIGIT-1:0] ^ msb_flip;
`else
  assign ad = a_sh[DIGIT-1:0];
  assign bd = b_sh[DIGIT-1:0];
`endif

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (ad),
    .b  (bd),
    .lt (d_lt),
    .eq (d_eq)
  );

  // Higher digits override lower ones because the sweep runs LSB-first.
  assign le_next = d_lt | (d_eq & le);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shift registers are plain flops, not a memory, so they are cleared on reset too.
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      le     <= 1'b1;
      lteq_q <= 1'b0;
    end else if (accept) begin
      a_sh <= in_a;
      b_sh <= in_b;
      cnt  <= '0;
      le   <= 1'b1;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      cnt  <= cnt + CW'(1);
      le   <= le_next;
      if (last_digit) lteq_q <= le_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_lteq  = lteq_q;

endmodule

// File: tb/tb_serial_lteq_cmp.sv
// Self-checking bench for serial_lteq_cmp at DIGIT=4, 1 and 32 with a scoreboard queue.
module tb_serial_lteq_cmp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_a      [3];
  logic [31:0] in_b      [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        out_lteq  [3];
  logic        busy      [3];

  int ndig [3] = '{8, 32, 1};
  int checks = 0;
  int errors = 0;
  logic sb [$];

  always #5 clk = ~clk;

  serial_lteq_cmp #(.WIDTH(32), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_lteq(out_lteq[0]), .busy(busy[0]));

  serial_lteq_cmp #(.WIDTH(32), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_lteq(out_lteq[1]), .busy(busy[1]));

  serial_lteq_cmp #(.WIDTH(32), .DIGIT(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_lteq(out_lteq[2]), .busy(busy[2]));

  function automatic logic ref_le(input logic [31:0] a, input logic [31:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
    return $signed(a) <= $signed(b);
`else
    return a <= b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k; hold>0 keeps out_ready low that many cycles.
  task automatic do_pair(input int k, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    int   n;
    logic exp_v;
    @(negedge clk);
    in_a[k] = a; in_b[k] = b; in_valid[k] = 1'b1; out_ready[k] = (hold == 0);
    n = 0;
    while (!in_ready[k] && n < 100) begin @(negedge clk); n++; end
    if (!in_ready[k]) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(ref_le(a, b));
    @(negedge clk);
    in_valid[k] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid[k] && n < 200);
    check("latency", n, ndig[k]);
    exp_v = (sb.size() > 0) ? sb.pop_front() : 1'bx;
    check("lteq", out_lteq[k], exp_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid[k] = 1'b1; in_a[k] = b; in_b[k] = a;
      @(posedge clk); #1;
      check("hold_valid", out_valid[k], 1'b1);
      check("hold_lteq", out_lteq[k], exp_v);
      check("hold_in_ready", in_ready[k], 1'b0);
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_out_valid", out_valid[k], 1'b0);
    check("idle_in_ready", in_ready[k], 1'b1);
    check("idle_busy", busy[k], 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; out_ready[k] = 1'b1;
    end
    #1;
    check("rst_in_ready", in_ready[0], 1'b1);
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_out_lteq", out_lteq[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases at DIGIT=4.
    do_pair(0, 32'h0000_0005, 32'h0000_0007, 0);
    do_pair(0, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_pair(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    do_pair(0, 32'h1000_0000, 32'h0FFF_FFFF, 0);
    do_pair(0, 32'h0FFF_FFFF, 32'h1000_0000, 0);
    do_pair(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_pair(0, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    do_pair(0, 32'h1234_5678, 32'h1234_5677, 20);

    // Reset during the 4th RUN cycle discards the pending result.
    @(negedge clk);
    in_a[0] = 32'h0000_0001; in_b[0] = 32'h0000_0002; in_valid[0] = 1'b1;
    @(posedge clk);
    sb.push_back(ref_le(in_a[0], in_b[0]));
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy[0], 1'b0);
    @(posedge clk); #1;
    check("mid_rst_in_ready", in_ready[0], 1'b1);
    check("mid_rst_out_valid", out_valid[0], 1'b0);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_out_lteq", out_lteq[0], 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    do_pair(0, 32'hCAFE_0000, 32'hCAFD_FFFF, 0);

    // Edge cases at DIGIT=1 and DIGIT=32.
    do_pair(1, 32'h1000_0000, 32'h0FFF_FFFF, 0);
    do_pair(1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_pair(2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    do_pair(2, 32'hFFFF_FFFF, 32'h0000_0001, 3);

    // Random regression with a bias towards equal and near-equal operands.
    for (int k = 0; k < 3; k++) begin
      int cnt;
      cnt = (k == 1) ? 250 : 1000;
      for (int i = 0; i < cnt; i++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 7))
          0: b = a;
          1: b = a ^ (32'h1 << $urandom_range(0, 31));
          default: ;
        endcase
        do_pair(k, a, b, 0);
      end
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
